regmap_uart_bridge: RTL and testbench
=====================================

Name: regmap_uart_bridge

Overview:
Byte-stream command bridge sitting directly upstream of the register map. It parses 8-bit command bytes from a serial front end (UART RX via valid/ready) into register-map write strobes and read accesses. It returns acknowledge, data or error bytes on an outbound stream for the UART TX. Host access to all register-map registers goes through this block.

Parameters:
ADDR_WIDTH, 4, register-map address width; legal 1..8.
DATA_WIDTH, 8, register-map data width; fixed at 8 (one data byte per access).
TIMEOUT_CYCLES, 16, max cycles to wait for i_rdvalid before an error response; legal 2..255.

Ports:
i_clk  input  1  clock; all logic on rising edge
i_rst  input  1  synchronous active-high reset
i_rx_valid  input  1  inbound command byte valid
o_rx_ready  output  1  bridge can accept inbound byte
i_rx_data  input  8  inbound command byte
o_tx_valid  output  1  outbound response byte valid
i_tx_ready  input  1  downstream accepts response byte
o_tx_data  output  8  outbound response byte
o_wren  output  1  register-map write strobe, one cycle
o_addr  output  ADDR_WIDTH  register-map address, registered
o_wrdata  output  DATA_WIDTH  register-map write data, registered
i_rdvalid  input  1  register-map read data valid
i_rddata  input  DATA_WIDTH  register-map read data
o_busy  output  1  high in any state other than IDLE

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock i_clk, reset i_rst.
- Reset (i_rst=1 at an edge): state IDLE, o_wren=0, o_addr=0, o_wrdata=0, o_tx_valid=0, o_tx_data=0, timeout counter=0, error flag=0. Reset mid-transaction aborts it silently: no write strobe, no response.
- Byte accept: rx beat = i_rx_valid & o_rx_ready. tx beat = o_tx_valid & i_tx_ready.
- o_rx_ready = 1 only in IDLE, GET_ADDR and GET_DATA. o_tx_valid = 1 only in RESP_HDR and RESP_DATA.
- Command format: write = 0x57 ('W'), addr, data. Read = 0x52 ('R'), addr.
- Responses: write ok = 0x4B ('K'). Read ok = 0x44 ('D') followed by the data byte. Any error = 0x45 ('E'), single byte.
- FSM, one transition per accepted beat or per cycle as noted:
  - IDLE: on rx beat, 0x57 -> GET_ADDR (op=W); 0x52 -> GET_ADDR (op=R); any other byte -> RESP_HDR with 'E'.
  - GET_ADDR: on rx beat, latch address byte. Set error flag if bits [7:ADDR_WIDTH] are nonzero. Then:
    - op=W -> GET_DATA.
    - op=R with error -> RESP_HDR 'E'.
    - op=R without error -> READ_WAIT; o_addr loads at this edge and the counter clears.
  - GET_DATA: on rx beat, if error -> RESP_HDR 'E' (data byte consumed and discarded). Else o_addr and o_wrdata load at this edge -> WRITE.
  - WRITE: o_wren=1 for exactly this one cycle, o_addr/o_wrdata stable -> RESP_HDR 'K'.
  - READ_WAIT: o_wren=0 and the counter increments each cycle. i_rdvalid is ignored in the first cycle (counter=0) so the register map sees the new address. From counter>=1, i_rdvalid=1 captures i_rddata -> RESP_HDR 'D'. If the counter reaches TIMEOUT_CYCLES-1 without i_rdvalid -> RESP_HDR 'E'.
  - RESP_HDR: holds o_tx_data until tx beat. 'D' -> RESP_DATA; otherwise -> IDLE.
  - RESP_DATA: outputs the captured read byte, held until tx beat -> IDLE.
- o_addr and o_wrdata hold their last loaded values between transactions; they change only at the edges stated above.
- o_tx_data and o_tx_valid must not change while o_tx_valid=1 and i_tx_ready=0.
- Latency, write: data byte accepted at edge N -> o_wren high cycle N..N+1 -> o_tx_valid high from edge N+1.
- Latency, read: addr accepted at edge N -> earliest capture at edge N+2 -> 'D' valid from N+2.
- The bridge never drops inbound bytes (it deasserts ready instead). Only one command is in flight at a time.
- The error flag clears on entry to IDLE.

Test Plan:
- Reset: hold i_rst=1 for 2 cycles with i_rx_valid=1 -> o_rx_ready=0 during reset; afterwards all outputs 0, o_busy=0, no write strobe.
- Write: send 0x57,0x02,0xA5 with i_tx_ready=1 -> exactly one o_wren pulse with o_addr=0x2, o_wrdata=0xA5; response 0x4B.
- Read: regmap model with ro reg 0x3=0x33 and 1-cycle rdvalid; send 0x52,0x03 -> response 0x44 then 0x33. Also write 0x57,0x00,0x5A then 0x52,0x00 -> 0x44,0x5A.
- Errors:
  - Send 0x41 -> response 0x45, state back to IDLE.
  - Send 0x57,0x10,0x99 (ADDR_WIDTH=4) -> no o_wren, response 0x45.
  - Send 0x52,0xF0 -> response 0x45.
- Timeout: i_rdvalid tied 0, send 0x52,0x01 -> response 0x45 exactly TIMEOUT_CYCLES cycles after the address accept; o_busy high throughout.
- Backpressure: i_tx_ready=0 for 5 cycles during a 'D' response -> o_tx_data held 0x44 stable, o_rx_ready=0. Release -> 0x44 then the data byte, each transferred once. A reset asserted during READ_WAIT -> IDLE next cycle with no response.

Source files
------------

// File: rtl/regmap_uart_bridge.sv
// Byte-stream command bridge: parses 'W'/'R' commands arriving on a UART RX stream into
// register-map accesses and answers with 'K', 'D'+data or 'E' on the TX stream.
module regmap_uart_bridge #(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_rx_valid,
    output logic                  o_rx_ready,
    input  logic [7:0]            i_rx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic [7:0]            o_tx_data,
    output logic                  o_wren,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [DATA_WIDTH-1:0] o_wrdata,
    input  logic                  i_rdvalid,
    input  logic [DATA_WIDTH-1:0] i_rddata,
    output logic                  o_busy
);

    localparam logic [7:0] CMD_W    = 8'h57;
    localparam logic [7:0] CMD_R    = 8'h52;
    localparam logic [7:0] RSP_K    = 8'h4B;
    localparam logic [7:0] RSP_D    = 8'h44;
    localparam logic [7:0] RSP_E    = 8'h45;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GET_ADDR  = 3'd1,
        ST_GET_DATA  = 3'd2,
        ST_WRITE     = 3'd3,
        ST_READ_WAIT = 3'd4,
        ST_RESP_HDR  = 3'd5,
        ST_RESP_DATA = 3'd6
    } state_t;

    // An address byte is illegal when any bit above the register-map address range is set.
    function automatic logic addr_err(input logic [7:0] b);
        addr_err = ((b >> ADDR_WIDTH) != 8'h00);
    endfunction

    state_t                 state_r, state_s;
    logic                   op_rd_r, op_rd_s;
    logic                   err_r, err_s;
    logic [ADDR_WIDTH-1:0]  addr_lat_r, addr_lat_s;
    logic [7:0]             cnt_r, cnt_s;
    logic [DATA_WIDTH-1:0]  rd_data_r, rd_data_s;
    logic [ADDR_WIDTH-1:0]  addr_r, addr_s;
    logic [DATA_WIDTH-1:0]  wrdata_r, wrdata_s;
    logic [7:0]             tx_data_r, tx_data_s;
    logic                   wren_r, wren_s;
    logic                   tx_valid_r, tx_valid_s;
    logic                   rx_ready_r, rx_ready_s;
    logic                   busy_r, busy_s;
    logic                   rx_beat_s, tx_beat_s;

    assign rx_beat_s = i_rx_valid & rx_ready_r;
    assign tx_beat_s = tx_valid_r & i_tx_ready;

    // Next-state and next-output decode; handshake outputs are derived from the next state
    // so they are registered alongside it.
    always_comb begin
        state_s    = state_r;
        op_rd_s    = op_rd_r;
        err_s      = err_r;
        addr_lat_s = addr_lat_r;
        cnt_s      = cnt_r;
        rd_data_s  = rd_data_r;
        addr_s     = addr_r;
        wrdata_s   = wrdata_r;
        tx_data_s  = tx_data_r;
        case (state_r)
            ST_IDLE: begin
                if (rx_beat_s) begin
                    if (i_rx_data == CMD_W) begin
                        op_rd_s = 1'b0;
                        state_s = ST_GET_ADDR;
                    end else if (i_rx_data == CMD_R) begin
                        op_rd_s = 1'b1;
                        state_s = ST_GET_ADDR;
                    end else begin
                        tx_data_s = RSP_E;
                        state_s   = ST_RESP_HDR;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GET_ADDR: begin
                if (rx_beat_s) begin
                    addr_lat_s = i_rx_data[ADDR_WIDTH-1:0];
                    err_s      = addr_err(i_rx_data);
                    if (!op_rd_r) begin
                        state_s = ST_GET_DATA;
                    end else if (addr_err(i_rx_data)) begin
                        tx_data_s = RSP_E;
                        state_s   = ST_RESP_HDR;
                    end else begin
                        addr_s  = i_rx_data[ADDR_WIDTH-1:0];
                        cnt_s   = 8'd0;
                        state_s = ST_READ_WAIT;
                    end
                end else begin
                    state_s = ST_GET_ADDR;
                end
            end
            ST_GET_DATA: begin
                if (rx_beat_s) begin
                    if (err_r) begin
                        tx_data_s = RSP_E;
                        state_s   = ST_RESP_HDR;
                    end else begin
                        addr_s   = addr_lat_r;
                        wrdata_s = i_rx_data[DATA_WIDTH-1:0];
                        state_s  = ST_WRITE;
                    end
                end else begin
                    state_s = ST_GET_DATA;
                end
            end
            ST_WRITE: begin
                tx_data_s = RSP_K;
                state_s   = ST_RESP_HDR;
            end
            ST_READ_WAIT: begin
                cnt_s = cnt_r + 8'd1;
                // First wait cycle is skipped so the register map sees the new address.
                if ((cnt_r != 8'd0) && i_rdvalid) begin
                    rd_data_s = i_rddata;
                    tx_data_s = RSP_D;
                    state_s   = ST_RESP_HDR;
                end else if (cnt_r >= CNT_LAST) begin
                    tx_data_s = RSP_E;
                    state_s   = ST_RESP_HDR;
                end else begin
                    state_s = ST_READ_WAIT;
                end
            end
            ST_RESP_HDR: begin
                if (tx_beat_s && (tx_data_r == RSP_D)) begin
                    tx_data_s = 8'(rd_data_r);
                    state_s   = ST_RESP_DATA;
                end else if (tx_beat_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP_HDR;
                end
            end
            ST_RESP_DATA: begin
                if (tx_beat_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP_DATA;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        if (state_s == ST_IDLE) begin
            err_s = 1'b0;
        end else begin
            err_s = err_s;
        end
        wren_s     = (state_s == ST_WRITE);
        tx_valid_s = (state_s == ST_RESP_HDR) || (state_s == ST_RESP_DATA);
        rx_ready_s = (state_s == ST_IDLE) || (state_s == ST_GET_ADDR) || (state_s == ST_GET_DATA);
        busy_s     = (state_s != ST_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r    <= ST_IDLE;
            op_rd_r    <= 1'b0;
            err_r      <= 1'b0;
            addr_lat_r <= '0;
            cnt_r      <= 8'd0;
            rd_data_r  <= '0;
            addr_r     <= '0;
            wrdata_r   <= '0;
            tx_data_r  <= 8'h00;
            wren_r     <= 1'b0;
            tx_valid_r <= 1'b0;
            rx_ready_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            op_rd_r    <= op_rd_s;
            err_r      <= err_s;
            addr_lat_r <= addr_lat_s;
            cnt_r      <= cnt_s;
            rd_data_r  <= rd_data_s;
            addr_r     <= addr_s;
            wrdata_r   <= wrdata_s;
            tx_data_r  <= tx_data_s;
            wren_r     <= wren_s;
            tx_valid_r <= tx_valid_s;
            rx_ready_r <= rx_ready_s;
            busy_r     <= busy_s;
        end
    end

    assign o_rx_ready = rx_ready_r;
    assign o_tx_valid = tx_valid_r;
    assign o_tx_data  = tx_data_r;
    assign o_wren     = wren_r;
    assign o_addr     = addr_r;
    assign o_wrdata   = wrdata_r;
    assign o_busy     = busy_r;

endmodule

// File: tb/tb_regmap_uart_bridge.sv
// Bench for regmap_uart_bridge: table vectors, random command stream against a
// command-level model, and hand-written timing/backpressure/reset sequences.
module tb_regmap_uart_bridge;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       wren;
    logic [3:0] addr;
    logic [7:0] wrdata;
    logic       rdvalid;
    logic [7:0] rddata;
    logic       busy;

    int checks = 0;
    int failures = 0;
    logic rnd_ready = 1'b0;
    logic rdv_en = 1'b1;

    regmap_uart_bridge #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_rx_valid(rx_valid), .o_rx_ready(rx_ready), .i_rx_data(rx_data),
        .o_tx_valid(tx_valid), .i_tx_ready(tx_ready), .o_tx_data(tx_data),
        .o_wren(wren), .o_addr(addr), .o_wrdata(wrdata),
        .i_rdvalid(rdvalid), .i_rddata(rddata), .o_busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input int i);
        init_val = 8'(i * 17);
    endfunction

    // Register map: address 3 is read-only (0x33); read data lags the address by one cycle.
    logic [7:0] mem [16];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
        end else if (wren && addr != 4'h3) begin
            mem[addr] <= wrdata;
        end
        rddata <= mem[addr];
    end
    assign rdvalid = rdv_en;

    logic [7:0]  got_tx [$];
    logic [11:0] got_wr [$];
    logic [7:0]  exp_tx [$];
    logic [11:0] exp_wr [$];
    logic [7:0]  exp_mem [16];
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h00;

    // Transfer monitor and TX-stream invariants
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_valid && tx_ready) got_tx.push_back(tx_data);
            if (wren) got_wr.push_back({addr, wrdata});
            if (prev_stall) begin
                checks++;
                if (!tx_valid || tx_data != prev_data) begin
                    failures++;
                    $display("FAIL tx_hold: valid=%0b data=%02h required valid=1 data=%02h", tx_valid, tx_data, prev_data);
                end
            end
            if (tx_valid) begin
                checks++;
                if (rx_ready) begin
                    failures++;
                    $display("FAIL rx_ready_in_resp: rx_ready=1 required 0");
                end
            end
        end
        prev_stall <= !rst && tx_valid && !tx_ready;
        prev_data  <= tx_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) tx_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && n < 500) begin
            tick();
            n++;
        end
        if (!rx_ready) chk("rx_accept_timeout", 32'(rx_ready), 32'd1);
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 2000) begin
            tick();
            n++;
        end
        if (busy) chk("idle_timeout", 32'(busy), 32'd0);
        tick();
    endtask

    task automatic clear_q();
        got_tx.delete(); got_wr.delete(); exp_tx.delete(); exp_wr.delete();
    endtask

    task automatic compare_q(input string name);
        chk({name, "_ntx"}, 32'(got_tx.size()), 32'(exp_tx.size()));
        for (int k = 0; k < exp_tx.size() && k < got_tx.size(); k++)
            chk($sformatf("%s_tx%0d", name, k), 32'(got_tx[k]), 32'(exp_tx[k]));
        chk({name, "_nwr"}, 32'(got_wr.size()), 32'(exp_wr.size()));
        for (int k = 0; k < exp_wr.size() && k < got_wr.size(); k++)
            chk($sformatf("%s_wr%0d", name, k), 32'(got_wr[k]), 32'(exp_wr[k]));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) exp_mem[i] = init_val(i);
        tick();
    endtask

    typedef struct {
        logic [7:0] b0, b1, b2;
        int         nb;
        int         nresp;
        logic [7:0] r0, r1;
        logic       wr;
        logic [3:0] wa;
        logic [7:0] wd;
    } vec_t;

    vec_t tbl [12];

    initial begin
        logic [7:0] bb [3];
        logic [7:0] a, d, op;
        int n;
        logic ok;

        tbl[0]  = '{8'h57, 8'h02, 8'hA5, 3, 1, 8'h4B, 8'h00, 1'b1, 4'h2, 8'hA5};
        tbl[1]  = '{8'h52, 8'h03, 8'h00, 2, 2, 8'h44, 8'h33, 1'b0, 4'h0, 8'h00};
        tbl[2]  = '{8'h57, 8'h00, 8'h5A, 3, 1, 8'h4B, 8'h00, 1'b1, 4'h0, 8'h5A};
        tbl[3]  = '{8'h52, 8'h00, 8'h00, 2, 2, 8'h44, 8'h5A, 1'b0, 4'h0, 8'h00};
        tbl[4]  = '{8'h41, 8'h00, 8'h00, 1, 1, 8'h45, 8'h00, 1'b0, 4'h0, 8'h00};
        tbl[5]  = '{8'h57, 8'h10, 8'h99, 3, 1, 8'h45, 8'h00, 1'b0, 4'h0, 8'h00};
        tbl[6]  = '{8'h52, 8'hF0, 8'h00, 2, 1, 8'h45, 8'h00, 1'b0, 4'h0, 8'h00};
        tbl[7]  = '{8'h57, 8'h03, 8'h77, 3, 1, 8'h4B, 8'h00, 1'b1, 4'h3, 8'h77};
        tbl[8]  = '{8'h52, 8'h03, 8'h00, 2, 2, 8'h44, 8'h33, 1'b0, 4'h0, 8'h00};
        tbl[9]  = '{8'h52, 8'h02, 8'h00, 2, 2, 8'h44, 8'hA5, 1'b0, 4'h0, 8'h00};
        tbl[10] = '{8'h57, 8'h0F, 8'hFF, 3, 1, 8'h4B, 8'h00, 1'b1, 4'hF, 8'hFF};
        tbl[11] = '{8'h52, 8'h0F, 8'h00, 2, 2, 8'h44, 8'hFF, 1'b0, 4'h0, 8'h00};

        // Reset with a byte offered: nothing may be accepted.
        tx_ready = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h57;
        rst      = 1'b1;
        tick();
        chk("rst_rx_ready_c1", 32'(rx_ready), 32'd0);
        tick();
        chk("rst_rx_ready_c2", 32'(rx_ready), 32'd0);
        rx_valid = 1'b0;
        rst      = 1'b0;
        chk("rst_outputs", {20'(0), wren, tx_valid, busy, addr, wrdata}, 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        tick();
        chk("rst_idle_ready", 32'(rx_ready), 32'd1);
        chk("rst_idle_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 16; i++) exp_mem[i] = init_val(i);
        tick();
        chk("rst_no_strobe", 32'(got_wr.size()), 32'd0);

        // Table-driven command vectors
        for (int i = 0; i < 12; i++) begin
            clear_q();
            bb[0] = tbl[i].b0; bb[1] = tbl[i].b1; bb[2] = tbl[i].b2;
            exp_tx.push_back(tbl[i].r0);
            if (tbl[i].nresp == 2) exp_tx.push_back(tbl[i].r1);
            if (tbl[i].wr) exp_wr.push_back({tbl[i].wa, tbl[i].wd});
            for (int k = 0; k < tbl[i].nb; k++) send_byte(bb[k]);
            wait_idle();
            compare_q($sformatf("vec%0d", i));
        end

        // Randomized command stream against the command-level model
        do_reset();
        clear_q();
        rnd_ready = 1'b1;
        for (int c = 0; c < 80; c++) begin
            int kind = $urandom_range(0, 9);
            a = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 15));
            d = 8'($urandom);
            if (kind < 4) begin
                send_byte(8'h57); send_byte(a); send_byte(d);
                if (a < 8'd16) begin
                    exp_wr.push_back({a[3:0], d});
                    exp_tx.push_back(8'h4B);
                    if (a != 8'd3) exp_mem[a[3:0]] = d;
                end else begin
                    exp_tx.push_back(8'h45);
                end
            end else if (kind < 8) begin
                send_byte(8'h52); send_byte(a);
                if (a < 8'd16) begin
                    exp_tx.push_back(8'h44);
                    exp_tx.push_back(exp_mem[a[3:0]]);
                end else begin
                    exp_tx.push_back(8'h45);
                end
            end else begin
                do op = 8'($urandom); while (op == 8'h57 || op == 8'h52);
                send_byte(op);
                exp_tx.push_back(8'h45);
            end
            repeat ($urandom_range(0, 2)) tick();
        end
        wait_idle();
        rnd_ready = 1'b0;
        tx_ready  = 1'b1;
        compare_q("rand");

        // Write latency: strobe in the cycle after the data beat, 'K' the cycle after that.
        clear_q();
        send_byte(8'h57); send_byte(8'h05); send_byte(8'h3C);
        chk("wlat_wren", 32'(wren), 32'd1);
        chk("wlat_addr_data", {20'(0), addr, wrdata}, {20'(0), 4'h5, 8'h3C});
        chk("wlat_no_tx", 32'(tx_valid), 32'd0);
        tick();
        chk("wlat_wren_off", 32'(wren), 32'd0);
        chk("wlat_tx", {23'(0), tx_valid, tx_data}, {23'(0), 1'b1, 8'h4B});
        wait_idle();

        // Read latency: 'D' valid two edges after the address beat.
        clear_q();
        exp_tx.push_back(8'h44); exp_tx.push_back(8'h3C);
        send_byte(8'h52); send_byte(8'h05);
        chk("rlat_n1", 32'(tx_valid), 32'd0);
        tick();
        chk("rlat_n2", 32'(tx_valid), 32'd0);
        tick();
        chk("rlat_d", {23'(0), tx_valid, tx_data}, {23'(0), 1'b1, 8'h44});
        wait_idle();
        compare_q("rlat");

        // Timeout with rdvalid held low
        clear_q();
        rdv_en = 1'b0;
        exp_tx.push_back(8'h45);
        send_byte(8'h52); send_byte(8'h01);
        n  = 0;
        ok = 1'b1;
        while (!tx_valid && n < 100) begin
            if (!busy) ok = 1'b0;
            tick();
            n++;
        end
        chk("timeout_cycles", 32'(n), 32'(TO));
        chk("timeout_busy", 32'(ok & busy), 32'd1);
        chk("timeout_resp", 32'(tx_data), 32'h45);
        wait_idle();
        compare_q("timeout");
        rdv_en = 1'b1;

        // Backpressure on a 'D' response
        clear_q();
        tx_ready = 1'b0;
        exp_tx.push_back(8'h44); exp_tx.push_back(8'h33);
        send_byte(8'h52); send_byte(8'h03);
        n = 0;
        while (!tx_valid && n < 50) begin
            tick();
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp_hold%0d", k), {23'(0), tx_valid, tx_data}, {23'(0), 1'b1, 8'h44});
            chk($sformatf("bp_rx_ready%0d", k), 32'(rx_ready), 32'd0);
            tick();
        end
        tx_ready = 1'b1;
        wait_idle();
        compare_q("bp");

        // Reset in READ_WAIT aborts silently
        clear_q();
        rdv_en = 1'b0;
        send_byte(8'h52); send_byte(8'h01);
        tick(); tick(); tick();
        chk("mid_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_idle", {30'(0), busy, tx_valid}, 32'd0);
        repeat (TO + 4) tick();
        chk("mid_rst_no_resp", 32'(got_tx.size()), 32'd0);
        chk("mid_rst_no_wr", 32'(got_wr.size()), 32'd0);
        chk("mid_rst_busy_after", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
